// File: rtl/nv_ram_rwsp_param_pkg.sv
// Shared definitions for the parametrised 1R1W RAM: clear-FSM state encoding
// and the byte-lane merge used by both the write path and the read bypass.
package nv_ram_pkg;

  typedef enum logic {
    CLR = 1'b0,
    RDY = 1'b1
  } clr_state_e;

  // One byte lane of a masked write: take the new byte when the lane is enabled.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       lane_en);
    return lane_en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/nv_ram_rwsp_param_if.sv
// Read/write port bundle of the parametrised RAM; the RAM is the slave side.
interface nv_ram_rwsp_param_if
  import nv_ram_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 512
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = DW / 8;

  logic [AW-1:0] ra;
  logic          re;
  logic          ore;
  logic [DW-1:0] dout;
  logic [AW-1:0] wa;
  logic          we;
  logic [MW-1:0] wmask;
  logic [DW-1:0] di;
  logic [31:0]   pwrbus_ram_pd;
  logic          init_done;

  modport master (
    output ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
    input  dout, init_done
  );

  modport slave (
    input  ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
    output dout, init_done
  );

endinterface

// File: rtl/nv_ram_rwsp_param_clr_ctl.sv
// Clear engine: after reset it walks every address once, requesting a zero
// write per cycle, then parks in RDY until the next reset.
module nv_ram_clr_ctl
  import nv_ram_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int CLR_ON_RST = 1,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_done
);

  localparam clr_state_e RST_STATE = (CLR_ON_RST != 0) ? CLR : RDY;

  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          init_done_q, init_done_d;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    init_done_d = (state_q == RDY);
    if (state_q == CLR) begin
      clr_addr_d = clr_addr_q + AW'(1);
      if (clr_addr_q == AW'(DEPTH - 1)) begin
        state_d    = RDY;
        clr_addr_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RST_STATE;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
    end
  end

  assign clr_we    = (state_q == CLR);
  assign clr_addr  = clr_addr_q;
  assign init_done = init_done_q;

endmodule

// File: rtl/nv_ram_rwsp_param.sv
// Parametrised one-read/one-write synchronous RAM with byte mask, selectable
// read-during-write result, optional output register and clear-after-reset.
module nv_ram_rwsp_param
  import nv_ram_pkg::*;
#(
  parameter int DW         = 64,
  parameter int DEPTH      = 512,
  parameter int BYPASS     = 0,
  parameter int OUT_REG    = 1,
  parameter int CLR_ON_RST = 1
) (
  input logic                clk,
  input logic                rstn,
  nv_ram_rwsp_param_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int MW = DW / 8;

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          init_done;

  nv_ram_clr_ctl #(
    .DEPTH      (DEPTH),
    .CLR_ON_RST (CLR_ON_RST),
    .AW         (AW)
  ) u_clr_ctl (
    .clk       (clk),
    .rstn      (rstn),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  (* ram_style = "block" *) reg [DW-1:0] mem [DEPTH-1:0];

  logic          wa_ok, ra_ok, user_we, collide, mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] merged_wd, mem_wd, rd_word;
  logic [DW-1:0] rd_q, rd_d;

  // The clear engine owns the write port while active; user traffic is dropped.
  always_comb begin
    wa_ok     = ({1'b0, bus.wa} < (AW + 1)'(DEPTH));
    ra_ok     = ({1'b0, bus.ra} < (AW + 1)'(DEPTH));
    user_we   = !clr_we && bus.we && wa_ok;
    collide   = user_we && bus.re && (bus.ra == bus.wa);
    merged_wd = '0;
    for (int i = 0; i < MW; i++) begin
      merged_wd[8*i +: 8] = byte_merge(mem[bus.wa][8*i +: 8], bus.di[8*i +: 8], bus.wmask[i]);
    end
    mem_we  = clr_we || user_we;
    mem_wa  = clr_we ? clr_addr : bus.wa;
    mem_wd  = clr_we ? '0 : merged_wd;
    rd_word = ra_ok ? mem[bus.ra] : '0;
    rd_d    = rd_q;
    if (clr_we) begin
      rd_d = '0;
    end else if (bus.re) begin
      rd_d = ((BYPASS != 0) && collide) ? merged_wd : rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = bus.ore ? rd_q : dout_q;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dout_q <= '0;
        end else begin
          dout_q <= dout_d;
        end
      end

      assign bus.dout = dout_q;
    end else begin : g_no_out_reg
      assign bus.dout = rd_q;
    end
  endgenerate

  assign bus.init_done = init_done;

  // The power-down bus exists only for port compatibility with older RAM models.
  logic unused_ok;
  assign unused_ok = ^{bus.pwrbus_ram_pd, bus.ore};

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Bench for nv_ram_rwsp_param: two instances (old-data with output register,
// new-data without) driven in lockstep and compared to a word-level model.
module tb_nv_ram_rwsp_param;

  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int MW    = 8;
  localparam int NVEC  = 20;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] ra, wa;
  logic          re, ore, we;
  logic [MW-1:0] wmask;
  logic [DW-1:0] di;
  logic [31:0]   pwr;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  nv_ram_rwsp_param_if #(.DW(DW), .DEPTH(DEPTH)) bus_a ();
  nv_ram_rwsp_param_if #(.DW(DW), .DEPTH(DEPTH)) bus_b ();

  assign bus_a.ra = ra;
  assign bus_a.re = re;
  assign bus_a.ore = ore;
  assign bus_a.wa = wa;
  assign bus_a.we = we;
  assign bus_a.wmask = wmask;
  assign bus_a.di = di;
  assign bus_a.pwrbus_ram_pd = pwr;
  assign bus_b.ra = ra;
  assign bus_b.re = re;
  assign bus_b.ore = ore;
  assign bus_b.wa = wa;
  assign bus_b.we = we;
  assign bus_b.wmask = wmask;
  assign bus_b.di = di;
  assign bus_b.pwrbus_ram_pd = pwr;

  nv_ram_rwsp_param #(
    .DW(DW), .DEPTH(DEPTH), .BYPASS(0), .OUT_REG(1), .CLR_ON_RST(1)
  ) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a)
  );

  nv_ram_rwsp_param #(
    .DW(DW), .DEPTH(DEPTH), .BYPASS(1), .OUT_REG(0), .CLR_ON_RST(1)
  ) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b)
  );

  // Reference model: word array plus the visible read/output registers.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd_old, m_rd_new, m_dout_reg;
  logic          m_ready, m_init;
  int            m_clr_cnt;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [MW-1:0] wmask;
    logic [DW-1:0] di;
    logic          re;
    logic [AW-1:0] ra;
    logic          ore;
    logic [DW-1:0] exp_reg;
    logic [DW-1:0] exp_byp;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [DW-1:0] model_merge(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MW; i++) begin
      if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_rd_old   = '0;
    m_rd_new   = '0;
    m_dout_reg = '0;
    m_ready    = 1'b0;
    m_init     = 1'b0;
    m_clr_cnt  = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    we    = v.we;
    wa    = v.wa;
    wmask = v.wmask;
    di    = v.di;
    re    = v.re;
    ra    = v.ra;
    ore   = v.ore;
  endtask

  // Advance one clock edge: predict from the current inputs, then compare.
  task automatic stepCycle();
    logic [DW-1:0] n_old, n_new, n_dout, old_word, merged;
    logic          n_ready, n_init;
    n_old   = m_rd_old;
    n_new   = m_rd_new;
    n_ready = m_ready;
    n_init  = m_ready;
    n_dout  = ore ? m_rd_old : m_dout_reg;
    if (!rstn) begin
      n_old = '0; n_new = '0; n_dout = '0; n_ready = 1'b0; n_init = 1'b0;
      m_clr_cnt = 0;
    end else if (!m_ready) begin
      m_clr_cnt++;
      n_ready = (m_clr_cnt == DEPTH);
      n_old = '0;
      n_new = '0;
    end else begin
      old_word = m_mem[ra];
      merged   = model_merge(m_mem[wa], di, wmask);
      if (re) begin
        n_old = old_word;
        n_new = (we && (wa == ra)) ? merged : old_word;
      end
      if (we) m_mem[wa] = merged;
    end
    @(posedge clk);
    #1;
    m_rd_old   = n_old;
    m_rd_new   = n_new;
    m_dout_reg = n_dout;
    m_ready    = n_ready;
    m_init     = n_init;
    checkOutput("dout_reg", bus_a.dout, m_dout_reg);
    checkOutput("dout_byp", bus_b.dout, m_rd_new);
    checkOutput("init_a", {63'b0, bus_a.init_done}, {63'b0, m_init});
    checkOutput("init_b", {63'b0, bus_b.init_done}, {63'b0, m_init});
  endtask

  task automatic run_clear(input bit poke, input string name);
    int edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < DEPTH + 20) begin
      if (poke && edges < DEPTH - 1) begin
        we = 1'b1; re = 1'b1; wa = AW'(3); ra = AW'(3); di = 64'h1234; wmask = '1; ore = 1'b1;
      end else begin
        we = 1'b0; re = 1'b0; ore = 1'b1;
      end
      stepCycle();
      edges++;
      if (bus_a.init_done === 1'b1) seen = 1'b1;
    end
    checkOutput(name, 64'(edges), 64'(DEPTH + 1));
  endtask

  task automatic assert_reset(input string name);
    rstn = 1'b0;
    #1;
    model_reset();
    checkOutput({name, "_dout_reg"}, bus_a.dout, '0);
    checkOutput({name, "_dout_byp"}, bus_b.dout, '0);
    checkOutput({name, "_init"}, {63'b0, bus_a.init_done}, '0);
    repeat (2) stepCycle();
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 9'd5, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 9'd0, 1'b1, 64'h0, 64'h0};
    vecs[1]  = '{1'b1, 9'd5, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 1'b0, 9'd0, 1'b1, 64'h0, 64'h0};
    vecs[2]  = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b1, 9'd5, 1'b1, 64'h0, 64'h01234567FFFFFFFF};
    vecs[3]  = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b0, 9'd0, 1'b1, 64'h01234567FFFFFFFF, 64'h01234567FFFFFFFF};
    vecs[4]  = '{1'b1, 9'd9, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 1'b0, 9'd0, 1'b1, 64'h01234567FFFFFFFF, 64'h01234567FFFFFFFF};
    vecs[5]  = '{1'b1, 9'd9, 8'hFF, 64'h5555555555555555, 1'b1, 9'd9, 1'b0, 64'h01234567FFFFFFFF, 64'h5555555555555555};
    vecs[6]  = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b0, 9'd0, 1'b0, 64'h01234567FFFFFFFF, 64'h5555555555555555};
    vecs[7]  = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b0, 9'd0, 1'b1, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555};
    vecs[8]  = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b1, 9'd9, 1'b1, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555};
    vecs[9]  = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b0, 9'd0, 1'b1, 64'h5555555555555555, 64'h5555555555555555};
    vecs[10] = '{1'b1, 9'd9, 8'h00, 64'h1111111111111111, 1'b0, 9'd0, 1'b1, 64'h5555555555555555, 64'h5555555555555555};
    vecs[11] = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b1, 9'd9, 1'b1, 64'h5555555555555555, 64'h5555555555555555};
    vecs[12] = '{1'b1, 9'd9, 8'h01, 64'h0000000000000012, 1'b1, 9'd9, 1'b1, 64'h5555555555555555, 64'h5555555555555512};
    vecs[13] = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b1, 9'd9, 1'b1, 64'h5555555555555555, 64'h5555555555555512};
    vecs[14] = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b0, 9'd0, 1'b1, 64'h5555555555555512, 64'h5555555555555512};
    vecs[15] = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b1, 9'd3, 1'b1, 64'h5555555555555512, 64'h0};
    vecs[16] = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b0, 9'd0, 1'b1, 64'h0, 64'h0};
    vecs[17] = '{1'b1, 9'd7, 8'hF0, 64'hDEADBEEFCAFEF00D, 1'b0, 9'd0, 1'b1, 64'h0, 64'h0};
    vecs[18] = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b1, 9'd7, 1'b1, 64'h0, 64'hDEADBEEF00000000};
    vecs[19] = '{1'b0, 9'd0, 8'h00, 64'h0, 1'b0, 9'd0, 1'b1, 64'hDEADBEEF00000000, 64'hDEADBEEF00000000};

    we = 1'b0; re = 1'b0; ore = 1'b0; wa = '0; ra = '0; wmask = '0; di = '0; pwr = '0;
    model_reset();
    repeat (3) stepCycle();
    checkOutput("rst_dout_reg", bus_a.dout, '0);
    checkOutput("rst_dout_byp", bus_b.dout, '0);
    checkOutput("rst_init", {63'b0, bus_a.init_done}, '0);
    rstn = 1'b1;

    run_clear(1'b1, "clr_len_first");

    for (int a = 0; a < DEPTH; a++) begin
      we = 1'b0; re = 1'b1; ra = AW'(a); ore = 1'b1;
      stepCycle();
    end

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("vec%0d_reg", i), bus_a.dout, vecs[i].exp_reg);
      checkOutput($sformatf("vec%0d_byp", i), bus_b.dout, vecs[i].exp_byp);
    end

    for (int n = 0; n < 2000; n++) begin
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      ore   = ($urandom_range(0, 3) != 0);
      wa    = (n % 4 == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 15));
      ra    = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
      wmask = MW'($urandom);
      di    = {$urandom, $urandom};
      pwr   = $urandom;
      stepCycle();
    end

    we = 1'b0; re = 1'b0; ore = 1'b1;
    assert_reset("rst_midop");
    repeat (200) stepCycle();
    assert_reset("rst_midclr");
    run_clear(1'b0, "clr_len_restart");

    we = 1'b0; re = 1'b1; ra = AW'(9); ore = 1'b1;
    stepCycle();
    checkOutput("post_rst_rd9", bus_b.dout, '0);
    re = 1'b1; ra = AW'(5);
    stepCycle();
    checkOutput("post_rst_rd5", bus_b.dout, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nv_ram_rwsp_param.md
# nv_ram_rwsp_param

Parametrised one-read/one-write synchronous RAM model for FPGA builds. It is the successor to the fixed-size 1R1W RAM models. It adds:
- configurable width and depth
- byte-lane write mask
- selectable read-during-write behaviour
- an optional output pipeline register
- a reset-triggered clear engine that zeroes the array before first use

It sits wherever NVDLA datapath buffers instantiate a `nv_ram_rws*`/`nv_ram_rwsp*` model, and maps to block RAM.

## Interface
- `DW`, 64, data width in bits; must be a multiple of 8.
- `DEPTH`, 512, number of words; ≥2.
- `AW`, `$clog2(DEPTH)`, address width; derived, not overridden.
- `MW`, `DW/8`, write-mask width; derived.
- `BYPASS`, 0, read-during-write to the same address: 0 returns old data, 1 returns newly written (masked-merged) data.
- `OUT_REG`, 1, 1 adds an output register gated by `ore`.
- `CLR_ON_RST`, 1, 1 zeroes all words after each reset.

Ports:
- `clk` in 1: sole clock; all logic on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `ra` in AW: read address.
- `re` in 1: read enable.
- `ore` in 1: output-register enable; ignored when `OUT_REG=0`.
- `dout` out DW: read data.
- `wa` in AW: write address.
- `we` in 1: write enable.
- `wmask` in MW: per-byte write enable; bit i covers `di[8i+7:8i]`.
- `di` in DW: write data.
- `pwrbus_ram_pd` in 32: power-down bus; kept for port compatibility, functionally ignored.
- `init_done` out 1: high when the array is usable.

## Operation
- Clear FSM states: `CLR`, `RDY`.
  - Reset enters `CLR` when `CLR_ON_RST=1`, otherwise `RDY`.
  - In `CLR`, a counter `clr_addr` (AW bits) writes zero to one word per cycle, from 0 to DEPTH-1.
  - On the cycle `clr_addr==DEPTH-1` is written, the FSM moves to `RDY`.
  - `RDY` is terminal until the next reset.
- `init_done` = (state==`RDY`), registered.
- While in `CLR`:
  - `we` and `re` are ignored; no user write occurs.
  - The read-data register `rd_q` holds 0.
- Write in `RDY`: when `we` is high, each byte lane i with `wmask[i]=1` is updated with the corresponding bytes of `di`. Lanes with `wmask[i]=0` keep their contents. `we` with `wmask=0` is a no-op.
- Read in `RDY`: when `re` is high, `rd_q` is loaded with `M[ra]`. When `re` is low, `rd_q` holds its value.
- Collision (`re & we & ra==wa`):
  - `BYPASS=0`: `rd_q` gets pre-write contents.
  - `BYPASS=1`: `rd_q` gets the byte merge `wmask ? di : M[ra]`.
  - The array is written in both cases.
- Output:
  - `OUT_REG=0`: `dout = rd_q`.
  - `OUT_REG=1`: `dout_q` loads `rd_q` when `ore` is high and holds otherwise; `dout = dout_q`.
- Out-of-range addresses (≥DEPTH when DEPTH is not a power of 2): writes are dropped and reads return 0.

## Timing
- Reset values: `rd_q=0`, `dout_q=0`, `dout=0`, `clr_addr=0`.
  - `init_done=0` when `CLR_ON_RST=1`.
  - `init_done=1` from the first edge after `rstn` deasserts when `CLR_ON_RST=0`.
- Clear duration: `init_done` rises exactly DEPTH+1 cycles after the first rising edge with `rstn` high.
- Read latency:
  - `OUT_REG=0`: `re` at edge N gives `dout` valid after edge N.
  - `OUT_REG=1`: `re` at edge N and `ore` at edge N+1 give `dout` valid after edge N+1.
- A write at edge N is visible to a read issued at edge N+1 or later, independent of `BYPASS`.
- Back-to-back reads and writes are allowed every cycle; there is no stall or backpressure.
- `rstn` asserted mid-clear or mid-operation:
  - All registers return immediately to their reset values.
  - The clear restarts from address 0.
  - Array contents are undefined until the clear completes.

## Structure
- Shared package `nv_ram_pkg`: FSM state encoding `CLR`/`RDY`, and the byte-merge function used by both the write path and the bypass path.
- One sub-module, `nv_ram_clr_ctl`: holds the clear FSM and `clr_addr` counter. It outputs `clr_we`, `clr_addr` and `init_done`; the top muxes these over the user write port.
- The array is a single `reg [DW-1:0] M [DEPTH-1:0]` with the block-RAM style attribute.

## Test plan
- Reset, then wait with `CLR_ON_RST=1`, DEPTH=512 → `init_done` is 0 for 512 cycles and 1 at cycle 513. Reading every address then returns 0.
- Write `0x0123456789ABCDEF` to address 5 with `wmask=0xFF`, then write `0xFFFF...` to address 5 with `wmask=0x0F`, then read address 5 → `0x01234567FFFFFFFF`. `dout` arrives 1 cycle after `re` with `OUT_REG=0`, or 2 cycles with `OUT_REG=1` and `ore=1`.
- Collision at address 9 (old value `0xAA..AA`, `di=0x55..55`, full mask):
  - `BYPASS=0` → `dout=0xAA..AA`.
  - `BYPASS=1` → `dout=0x55..55`.
  - A subsequent read of address 9 returns `0x55..55` in both cases.
- With `OUT_REG=1`, hold `ore=0` after a read → `dout` keeps its previous value. Assert `ore` → the new data appears one edge later.
- Assert `rstn` low at clear address 200, then release → `dout=0` and `init_done=0` immediately. The clear restarts, and `init_done` rises DEPTH+1 cycles after release.
- Issue `we` and `re` during `CLR` to address 3 with data `0x1234` → no effect. After `init_done`, address 3 reads 0.
